debug_uart_tx: RTL and testbench



---
 rtl/debug_link_pkg.sv | 30 +++
 rtl/uart_tx_byte.sv | 63 ++++++
 rtl/debug_uart_tx.sv | 122 ++++++++++++
 tb/tb_debug_uart_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_link_pkg.sv
// Shared constants and types for the CPU serial debug link framing.
package debug_link_pkg;
   localparam logic [7:0] DBG_SYNC_BYTE      = 8'hA5;
   localparam int         DBG_NUM_PORTS      = 7;
   localparam int         DBG_BYTES_PER_PORT = 3;
   localparam int         DBG_PAYLOAD_BYTES  = DBG_NUM_PORTS * DBG_BYTES_PER_PORT;
   localparam int         DBG_FRAME_BYTES    = DBG_PAYLOAD_BYTES + 2;
   localparam int         DBG_SNAP_W         = DBG_PAYLOAD_BYTES * 8;
   localparam int         UART_FRAME_BITS    = 10;

   typedef logic [4:0] dbg_byte_idx_t;

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } dbg_state_e;

   // Frame index 1..DBG_PAYLOAD_BYTES maps MSB-first onto the snapshot; other indices give 0.
   function automatic logic [7:0] dbg_snap_byte(input logic [DBG_SNAP_W-1:0] snap,
                                                input dbg_byte_idx_t         idx);
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < DBG_PAYLOAD_BYTES; i++) begin
         if (idx == dbg_byte_idx_t'(i + 1)) begin
            b = snap[DBG_SNAP_W-1-8*i -: 8];
         end
      end
      return b;
   endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: tx drops to the start bit the cycle after valid&&ready, each bit held CLKS_PER_BIT cycles.
// ready is high when idle or on the byte_done cycle, so a waiting byte follows the stop bit with no gap.
module uart_tx_byte
   import debug_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       byte_done
);
   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       LAST_BIT = 4'(UART_FRAME_BITS - 1);

   logic             r_active;
   logic [CNT_W-1:0] r_baud_cnt;
   logic [3:0]       r_bit_idx;
   logic [8:0]       r_shift;
   logic             r_tx;

   logic w_bit_end;
   logic w_load;

   assign w_bit_end = r_active && (r_baud_cnt == CNT_MAX);
   assign byte_done = w_bit_end && (r_bit_idx == LAST_BIT);
   assign ready     = !r_active || byte_done;
   assign w_load    = valid && ready;
   assign tx        = r_tx;

   // r_shift carries the data bits with the stop bit behind them, so the stop level falls out of the shift.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_active   <= 1'b0;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
      end else if (w_load) begin
         r_active   <= 1'b1;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= {1'b1, data};
         r_tx       <= 1'b0;
      end else if (w_bit_end) begin
         r_baud_cnt <= '0;
         if (r_bit_idx == LAST_BIT) begin
            r_active <= 1'b0;
            r_tx     <= 1'b1;
         end else begin
            r_bit_idx <= r_bit_idx + 4'd1;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b1, r_shift[8:1]};
         end
      end else if (r_active) begin
         r_baud_cnt <= r_baud_cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/debug_uart_tx.sv
// Snapshots seven 24-bit debug ports on start and sends SYNC, 21 payload bytes and a mod-256 checksum over 8N1.
// start is ignored while busy; done pulses with busy low the cycle after the last stop bit, where start is accepted again.
module debug_uart_tx
   import debug_link_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] SYNC_BYTE    = DBG_SYNC_BYTE
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        start,
   input  logic [23:0] debug_port1,
   input  logic [23:0] debug_port2,
   input  logic [23:0] debug_port3,
   input  logic [23:0] debug_port4,
   input  logic [23:0] debug_port5,
   input  logic [23:0] debug_port6,
   input  logic [23:0] debug_port7,
   output logic        tx,
   output logic        busy,
   output logic        done
);
   localparam dbg_byte_idx_t LAST_IDX = dbg_byte_idx_t'(DBG_FRAME_BYTES - 1);

   dbg_state_e              r_state;
   dbg_state_e              w_state_nxt;
   logic [DBG_SNAP_W-1:0]   r_snap;
   dbg_byte_idx_t           r_byte_idx;
   logic [7:0]              r_csum;
   logic                    r_done;

   dbg_byte_idx_t w_idx_nxt;
   logic          w_valid;
   logic          w_ready;
   logic          w_byte_done;
   logic          w_accept;
   logic          w_last;
   logic          w_add_csum;
   logic [7:0]    w_data;

   assign w_idx_nxt = r_byte_idx + 5'd1;
   assign busy      = (r_state == ST_SEND);
   assign done      = r_done;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The next byte is chosen on the byte_done cycle so the serialiser never idles mid-frame.
   always_comb begin
      w_state_nxt = r_state;
      w_valid     = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      w_add_csum  = 1'b0;
      w_data      = SYNC_BYTE;
      case (r_state)
         ST_IDLE: begin
            if (start && w_ready) begin
               w_accept    = 1'b1;
               w_valid     = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (w_byte_done) begin
               if (r_byte_idx == LAST_IDX) begin
                  w_last      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_valid = 1'b1;
                  if (w_idx_nxt == LAST_IDX) begin
                     w_data = r_csum;
                  end else begin
                     w_data     = dbg_snap_byte(r_snap, w_idx_nxt);
                     w_add_csum = 1'b1;
                  end
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_snap     <= '0;
         r_byte_idx <= '0;
         r_csum     <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_accept) begin
            r_snap     <= {debug_port1, debug_port2, debug_port3, debug_port4,
                           debug_port5, debug_port6, debug_port7};
            r_byte_idx <= '0;
            r_csum     <= '0;
         end else if (w_valid) begin
            r_byte_idx <= w_idx_nxt;
            if (w_add_csum) begin
               r_csum <= r_csum + w_data;
            end
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clk      (clk),
      .nreset   (nreset),
      .data     (w_data),
      .valid    (w_valid),
      .ready    (w_ready),
      .tx       (tx),
      .byte_done(w_byte_done)
   );
endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: decodes the serial line and compares each frame against a byte-list model.
module tb_debug_uart_tx;
   localparam int CPB       = 4;
   localparam int FRAME_CYC = 23 * 10 * CPB;

   logic        clk = 1'b0;
   logic        nreset;
   logic        start;
   logic [23:0] dp [7];
   logic        tx;
   logic        busy;
   logic        done;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   logic       busy_at_done = 1'b1;
   logic [7:0] exp_f [23];
   logic [7:0] got_f [23];
   int         t0 = 0;

   debug_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .clk        (clk),
      .nreset     (nreset),
      .start      (start),
      .debug_port1(dp[0]),
      .debug_port2(dp[1]),
      .debug_port3(dp[2]),
      .debug_port4(dp[3]),
      .debug_port5(dp[4]),
      .debug_port6(dp[5]),
      .debug_port7(dp[6]),
      .tx         (tx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt     = done_cnt + 1;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Frame = sync, each port's bytes MSB first, then the payload sum mod 256.
   function automatic void model_frame();
      int sum;
      sum      = 0;
      exp_f[0] = 8'hA5;
      for (int p = 0; p < 7; p++) begin
         for (int k = 0; k < 3; k++) begin
            exp_f[1 + 3*p + k] = 8'((dp[p] >> (16 - 8*k)) & 24'hFF);
            sum += int'(exp_f[1 + 3*p + k]);
         end
      end
      exp_f[22] = 8'(sum % 256);
   endfunction

   task automatic decode_frame();
      int ferr;
      int w;
      ferr = 0;
      w    = 0;
      while (tx !== 1'b0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      chk("tx_start_seen", {31'b0, tx}, 32'd0);
      t0 = cyc;
      for (int b = 0; b < 23; b++) got_f[b] = 8'h00;
      if (tx === 1'b0) begin
         repeat (2) @(negedge clk);
         for (int b = 0; b < 23; b++) begin
            if (tx !== 1'b0) ferr++;
            for (int j = 0; j < 8; j++) begin
               repeat (CPB) @(negedge clk);
               got_f[b][j] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) ferr++;
            if (b < 22) repeat (CPB) @(negedge clk);
         end
      end
      chk("framing_bits", ferr, 0);
   endtask

   task automatic compare_bytes(input string tag);
      for (int b = 0; b < 23; b++) begin
         chk($sformatf("%s_byte%0d", tag, b), {24'b0, got_f[b]}, {24'b0, exp_f[b]});
      end
   endtask

   task automatic finish_done(input string tag, input int base);
      int w;
      w = 0;
      while (done_cnt == base && w < 20) begin
         @(negedge clk);
         #1;
         w++;
      end
      repeat (4) begin
         @(negedge clk);
         #1;
      end
      chk({tag, "_done_count"}, done_cnt - base, 1);
      chk({tag, "_done_latency"}, done_cyc - t0, FRAME_CYC);
      chk({tag, "_busy_at_done"}, {31'b0, busy_at_done}, 32'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_frame(input string tag);
      int base;
      model_frame();
      base = done_cnt;
      fork
         decode_frame();
         pulse_start();
      join
      compare_bytes(tag);
      finish_done(tag, base);
   endtask

   initial begin
      int base;
      int lows;
      int w;
      int d_cyc;
      logic seen;

      // Reset held with start asserted
      nreset = 1'b0;
      start  = 1'b1;
      for (int p = 0; p < 7; p++) dp[p] = 24'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_tx", {31'b0, tx}, 32'd1);
         chk("rst_busy", {31'b0, busy}, 32'd0);
         chk("rst_done", {31'b0, done}, 32'd0);
      end
      start  = 1'b0;
      nreset = 1'b1;
      lows   = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) lows++;
      end
      chk("idle_after_reset", lows, 0);

      // Single frame
      dp[0] = 24'h123456;
      run_frame("single");
      chk("single_csum", {24'b0, got_f[22]}, 32'h9C);

      // Checksum wrap
      for (int p = 0; p < 7; p++) dp[p] = 24'hFFFFFF;
      run_frame("wrap");
      chk("wrap_csum", {24'b0, got_f[22]}, 32'hEB);

      // Random frames
      for (int n = 0; n < 2; n++) begin
         for (int p = 0; p < 7; p++) dp[p] = 24'($urandom);
         run_frame($sformatf("rand%0d", n));
      end

      // Snapshot isolation and start ignored while busy
      for (int p = 0; p < 7; p++) dp[p] = 24'($urandom);
      dp[2] = 24'hABCDEF;
      model_frame();
      base = done_cnt;
      fork
         decode_frame();
         begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            dp[2] = 24'h000000;
            @(negedge clk);
            chk("snap_busy_high", {31'b0, busy}, 32'd1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      compare_bytes("snap");
      finish_done("snap", base);
      lows = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("snap_no_second_frame", lows, 0);

      // Back-to-back: start in the done cycle with fresh ports
      for (int p = 0; p < 7; p++) dp[p] = 24'($urandom);
      model_frame();
      base  = done_cnt;
      d_cyc = 0;
      seen  = 1'b0;
      fork
         decode_frame();
         begin
            pulse_start();
            w = 0;
            while (done !== 1'b1 && w < 1200) begin
               @(negedge clk);
               w++;
            end
            seen  = done;
            d_cyc = cyc;
            for (int p = 0; p < 7; p++) dp[p] = 24'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      chk("b2b_done_seen", {31'b0, seen}, 32'd1);
      compare_bytes("b2bA");
      chk("b2bA_done_latency", done_cyc - t0, FRAME_CYC);
      chk("b2bA_busy_at_done", {31'b0, busy_at_done}, 32'd0);
      model_frame();
      base = done_cnt;
      decode_frame();
      chk("b2b_gap", t0 - d_cyc, 1);
      compare_bytes("b2bB");
      finish_done("b2bB", base);

      // Reset during byte 5
      for (int p = 0; p < 7; p++) dp[p] = 24'($urandom);
      pulse_start();
      repeat (5 * 10 * CPB + 10) @(negedge clk);
      chk("mid_busy_before", {31'b0, busy}, 32'd1);
      #2;
      nreset = 1'b0;
      #1;
      chk("mid_rst_tx", {31'b0, tx}, 32'd1);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_done", {31'b0, done}, 32'd0);
      repeat (3) @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      chk("mid_idle_tx", {31'b0, tx}, 32'd1);
      for (int p = 0; p < 7; p++) dp[p] = 24'($urandom);
      run_frame("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
